// File: rtl/tile_irq_agent.sv
// Tile interrupt agent: edge-detects local sources into PENDING and presents them one at a time on a two-channel INT request to the Dock.
// It also holds a sticky NMI request. Defining TILE_IRQ_VECTOR_EN adds the VBASE register and the ack_vector/ack_vector_valid outputs.
module tile_irq_agent #(
  parameter int NUM_SRC    = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_event,
  input  logic               nmi_event,
  input  logic               slot_ack,
  output logic [1:0]         int_req,
  output logic               nmi_req,
  input  logic               reg_wr_en,
  input  logic               reg_rd_en,
  input  logic [3:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
`ifdef TILE_IRQ_VECTOR_EN
  output logic [7:0]         ack_vector,
  output logic               ack_vector_valid,
`endif
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ASSERT    = 2'd1,
    ST_INSERVICE = 2'd2,
    ST_GAP       = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] chmap_q, chmap_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] prev_q;
  logic               nmi_prev_q;
  logic               nmi_q, nmi_d;
  logic               spurious_q, spurious_d;
  logic [3:0]         cur_src_q, cur_src_d;
  logic               cur_ch_q, cur_ch_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;
  logic [1:0]         int_req_q, int_req_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               wr_enable, wr_chmap, wr_pending, wr_eoi, wr_status, wr_nmiclr;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible, elig_ch0, elig_ch1;
  logic [NUM_SRC-1:0] cur_mask, ack_mask, w1c_mask;
  logic               ack_ok;
  logic [31:0]        rd_val;
  logic               unused_wdata;

  assign wr_enable  = reg_wr_en && (reg_addr == 4'h0);
  assign wr_chmap   = reg_wr_en && (reg_addr == 4'h1);
  assign wr_pending = reg_wr_en && (reg_addr == 4'h2);
  assign wr_eoi     = reg_wr_en && (reg_addr == 4'h3);
  assign wr_status  = reg_wr_en && (reg_addr == 4'h4);
  assign wr_nmiclr  = reg_wr_en && (reg_addr == 4'h5);

  assign rise     = src_event & ~prev_q;
  assign eligible = pending_q & enable_q;
  assign elig_ch0 = eligible & ~chmap_q;
  assign elig_ch1 = eligible & chmap_q;
  assign cur_mask = {{(NUM_SRC-1){1'b0}}, 1'b1} << cur_src_q;
  assign unused_wdata = ^reg_wdata;

  function automatic logic [3:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = 4'(i);
    end
  endfunction

  // Handshake: int_req[cur_ch] is held high from ASSERT through INSERVICE; a
  // slot_ack pulse while in ASSERT is the acceptance, and only then is the
  // request's pending bit consumed. Acks in any other state are spurious.
  always_comb begin
    state_d   = state_q;
    cur_src_d = cur_src_q;
    cur_ch_d  = cur_ch_q;
    gap_cnt_d = gap_cnt_q;
    ack_ok    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          if (|elig_ch0) begin
            cur_ch_d  = 1'b0;
            cur_src_d = lowest_idx(elig_ch0);
          end else begin
            cur_ch_d  = 1'b1;
            cur_src_d = lowest_idx(elig_ch1);
          end
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (slot_ack) begin
          ack_ok  = 1'b1;
          state_d = ST_INSERVICE;
        end else if (!(|(enable_q & cur_mask))) begin
          state_d   = ST_GAP;
          gap_cnt_d = 4'(GAP_CYCLES - 1);
        end
      end
      ST_INSERVICE: begin
        if (wr_eoi) begin
          state_d   = ST_GAP;
          gap_cnt_d = 4'(GAP_CYCLES - 1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 4'd0) state_d = ST_IDLE;
        else                   gap_cnt_d = gap_cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    int_req_d = 2'b00;
    if (state_d == ST_ASSERT || state_d == ST_INSERVICE) begin
      int_req_d = cur_ch_d ? 2'b10 : 2'b01;
    end
  end

  // New rising edges are OR-ed in last so a set always beats a same-cycle clear.
  always_comb begin
    ack_mask  = ack_ok ? cur_mask : '0;
    w1c_mask  = wr_pending ? reg_wdata[NUM_SRC-1:0] : '0;
    pending_d = (pending_q & ~(ack_mask | w1c_mask)) | rise;
    enable_d  = wr_enable ? reg_wdata[NUM_SRC-1:0] : enable_q;
    chmap_d   = wr_chmap ? reg_wdata[NUM_SRC-1:0] : chmap_q;
    nmi_d     = (nmi_q & ~(wr_nmiclr & reg_wdata[0])) | (nmi_event & ~nmi_prev_q);
    spurious_d = spurious_q;
    if (slot_ack && (state_q != ST_ASSERT)) spurious_d = 1'b1;
    else if (wr_status)                     spurious_d = 1'b0;
  end

`ifdef TILE_IRQ_VECTOR_EN
  logic [7:0] vbase_q;
  logic [7:0] vec_q;
  logic       vec_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vbase_q     <= 8'h00;
      vec_q       <= 8'h00;
      vec_valid_q <= 1'b0;
    end else begin
      if (reg_wr_en && (reg_addr == 4'h6)) vbase_q <= reg_wdata[7:0];
      vec_valid_q <= ack_ok;
      if (ack_ok) vec_q <= vbase_q + {4'h0, cur_src_q};
    end
  end

  assign ack_vector       = vec_q;
  assign ack_vector_valid = vec_valid_q;
`endif

  always_comb begin
    rd_val = 32'h0;
    case (reg_addr)
      4'h0: rd_val = 32'(enable_q);
      4'h1: rd_val = 32'(chmap_q);
      4'h2: rd_val = 32'(pending_q);
      4'h4: rd_val = {19'h0, spurious_q, nmi_q, state_q, cur_ch_q, 4'h0, cur_src_q};
`ifdef TILE_IRQ_VECTOR_EN
      4'h6: rd_val = {24'h0, vbase_q};
`endif
      default: rd_val = 32'h0;
    endcase
    rdata_d = reg_rd_en ? rd_val : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      enable_q   <= '0;
      chmap_q    <= '0;
      pending_q  <= '0;
      prev_q     <= '0;
      nmi_prev_q <= 1'b0;
      nmi_q      <= 1'b0;
      spurious_q <= 1'b0;
      cur_src_q  <= 4'h0;
      cur_ch_q   <= 1'b0;
      gap_cnt_q  <= 4'h0;
      int_req_q  <= 2'b00;
      rdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      chmap_q    <= chmap_d;
      pending_q  <= pending_d;
      prev_q     <= src_event;
      nmi_prev_q <= nmi_event;
      nmi_q      <= nmi_d;
      spurious_q <= spurious_d;
      cur_src_q  <= cur_src_d;
      cur_ch_q   <= cur_ch_d;
      gap_cnt_q  <= gap_cnt_d;
      int_req_q  <= int_req_d;
      rdata_q    <= rdata_d;
    end
  end

  assign int_req     = int_req_q;
  assign nmi_req     = nmi_q;
  assign reg_rdata   = rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tile_irq_agent.sv
// Bench for tile_irq_agent: service order, latencies and register side effects are derived from the block's rules.
// The expected service order comes from a rule-level picker fed with randomized enable/map/source sets.
module tb_tile_irq_agent;
  localparam int NS  = 8;
  localparam int GAP = 2;
  localparam logic [1:0] S_IDLE = 2'd0, S_ASSERT = 2'd1, S_INSERVICE = 2'd2, S_GAP = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NS-1:0] src_event = '0;
  logic          nmi_event = 1'b0;
  logic          slot_ack = 1'b0;
  logic [1:0]    int_req;
  logic          nmi_req;
  logic          reg_wr_en = 1'b0, reg_rd_en = 1'b0;
  logic [3:0]    reg_addr = 4'h0;
  logic [31:0]   reg_wdata = 32'h0;
  logic [31:0]   reg_rdata;
  logic [1:0]    dbg_state;
`ifdef TILE_IRQ_VECTOR_EN
  logic [7:0]    ack_vector;
  logic          ack_vector_valid;
`endif

  int checks = 0;
  int failures = 0;

  tile_irq_agent #(.NUM_SRC(NS), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .src_event(src_event), .nmi_event(nmi_event),
    .slot_ack(slot_ack), .int_req(int_req), .nmi_req(nmi_req),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
`ifdef TILE_IRQ_VECTOR_EN
    .ack_vector(ack_vector), .ack_vector_valid(ack_vector_valid),
`endif
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0; src_event = '0; nmi_event = 1'b0; slot_ack = 1'b0;
    reg_wr_en = 1'b0; reg_rd_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // at most one request line may ever be high
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (int_req == 2'b11) begin
        failures++;
        $display("FAIL onehot int_req=%b required one-hot or zero", int_req);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    reg_wr_en = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge clk);
    reg_wr_en = 1'b0; reg_wdata = 32'h0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    reg_rd_en = 1'b1; reg_addr = a;
    @(negedge clk);
    reg_rd_en = 1'b0;
    d = reg_rdata;
  endtask

  task automatic pulse_ack();
    slot_ack = 1'b1;
    @(negedge clk);
    slot_ack = 1'b0;
  endtask

  task automatic wait_req(input int maxc, output int n);
    n = 0;
    while (int_req == 2'b00 && n < maxc) begin
      @(negedge clk);
      n++;
    end
  endtask

  // reference picker: channel 0 first if any eligible source maps to it, then lowest index
  function automatic void pick(input logic [NS-1:0] elig, input logic [NS-1:0] map,
                               output int src, output int ch);
    src = -1; ch = -1;
    for (int c = 0; c < 2 && src < 0; c++) begin
      for (int i = 0; i < NS; i++) begin
        if (elig[i] && (int'(map[i]) == c) && src < 0) begin
          src = i; ch = c;
        end
      end
    end
  endfunction

  function automatic logic [31:0] status_word(input bit spur, input bit nmi, input logic [1:0] st,
                                              input int ch, input int src);
    return (32'(spur) << 12) | (32'(nmi) << 11) | (32'(st) << 9) | (32'(ch) << 8) | 32'(src);
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    checks++;
    if (int_req !== 2'b00 || nmi_req !== 1'b0 || reg_rdata !== 32'h0 || dbg_state !== S_IDLE) begin
      failures++;
      $display("FAIL reset_outputs int_req=%b nmi=%b rdata=%h state=%0d required 0", int_req, nmi_req, reg_rdata, dbg_state);
    end
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), d);
      checks++;
      if (d !== 32'h0) begin
        failures++;
        $display("FAIL reset_reg addr=%0h got=%h required 0", a, d);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    int n;
    do_reset();
    wr(4'h0, 32'h04);
    wr(4'h1, 32'h00);
    src_event[2] = 1'b1;
    wait_req(10, n);
    checks++;
    if (n !== 2 || int_req !== 2'b01) begin
      failures++;
      $display("FAIL basic_assert latency=%0d int_req=%b required 2 / 01", n, int_req);
    end
    rd(4'h4, d);
    checks++;
    if (d !== status_word(0, 0, S_ASSERT, 0, 2)) begin
      failures++;
      $display("FAIL basic_status_assert got=%h required %h", d, status_word(0, 0, S_ASSERT, 0, 2));
    end
    pulse_ack();
    checks++;
    if (int_req !== 2'b01) begin
      failures++;
      $display("FAIL basic_inservice_req got=%b required 01", int_req);
    end
    rd(4'h2, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL basic_pending got=%h required 0", d);
    end
    rd(4'h4, d);
    checks++;
    if (d !== status_word(0, 0, S_INSERVICE, 0, 2)) begin
      failures++;
      $display("FAIL basic_status_insvc got=%h required %h", d, status_word(0, 0, S_INSERVICE, 0, 2));
    end
    wr(4'h3, $urandom);
    for (int i = 0; i < GAP; i++) begin
      checks++;
      if (int_req !== 2'b00 || dbg_state !== S_GAP) begin
        failures++;
        $display("FAIL basic_gap cyc=%0d int_req=%b state=%0d required 00 / GAP", i, int_req, dbg_state);
      end
      tick();
    end
    checks++;
    if (int_req !== 2'b00 || dbg_state !== S_IDLE) begin
      failures++;
      $display("FAIL basic_idle int_req=%b state=%0d required 00 / IDLE", int_req, dbg_state);
    end
    src_event = '0;
  endtask

  task automatic test_priority(input int iters);
    logic [NS-1:0] en, map, pend;
    logic [31:0] d;
    int s, c, n, exp_lat;
    for (int it = 0; it < iters; it++) begin
      do_reset();
      if (it == 0) begin
        en = 8'h81; map = 8'h80; pend = 8'h81;
      end else begin
        en = NS'($urandom_range(1, 255)); map = NS'($urandom); pend = NS'($urandom_range(1, 255));
      end
      wr(4'h0, 32'(en));
      wr(4'h1, 32'(map));
      src_event = pend;
      exp_lat = 2;
      while ((pend & en) != '0) begin
        pick(pend & en, map, s, c);
        wait_req(20, n);
        checks++;
        if (n !== exp_lat || int_req !== (c == 1 ? 2'b10 : 2'b01)) begin
          failures++;
          $display("FAIL prio_req it=%0d src=%0d latency=%0d int_req=%b required %0d / ch%0d", it, s, n, int_req, exp_lat, c);
        end
        rd(4'h4, d);
        checks++;
        if (d !== status_word(0, 0, S_ASSERT, c, s)) begin
          failures++;
          $display("FAIL prio_status it=%0d got=%h required %h", it, d, status_word(0, 0, S_ASSERT, c, s));
        end
        pulse_ack();
        pend[s] = 1'b0;
        rd(4'h2, d);
        checks++;
        if (d !== 32'(pend)) begin
          failures++;
          $display("FAIL prio_pending it=%0d got=%h required %h", it, d, 32'(pend));
        end
        wr(4'h3, 32'h0);
        exp_lat = GAP + 1;
      end
      repeat (GAP + 3) tick();
      checks++;
      if (int_req !== 2'b00) begin
        failures++;
        $display("FAIL prio_drain it=%0d int_req=%b required 00", it, int_req);
      end
      src_event = '0;
    end
  endtask

  task automatic test_spurious();
    logic [31:0] d;
    do_reset();
    pulse_ack();
    checks++;
    if (int_req !== 2'b00 || nmi_req !== 1'b0) begin
      failures++;
      $display("FAIL spur_req int_req=%b nmi=%b required 00 / 0", int_req, nmi_req);
    end
    rd(4'h4, d);
    checks++;
    if (d !== 32'h1000) begin
      failures++;
      $display("FAIL spur_set got=%h required 00001000", d);
    end
    wr(4'h4, $urandom);
    rd(4'h4, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL spur_clear got=%h required 0", d);
    end
    wr(4'hA, 32'hFFFF_FFFF);
    rd(4'hA, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL unmapped got=%h required 0", d);
    end
  endtask

  task automatic test_disable();
    logic [31:0] d;
    logic [1:0] exp_req;
    int s, c, n;
    do_reset();
    s = $urandom_range(0, NS - 1);
    c = $urandom_range(0, 1);
    exp_req = (c == 1) ? 2'b10 : 2'b01;
    wr(4'h0, 32'h1 << s);
    wr(4'h1, 32'(c) << s);
    src_event[s] = 1'b1;
    wait_req(10, n);
    wr(4'h3, 32'h0);
    checks++;
    if (int_req !== exp_req || dbg_state !== S_ASSERT) begin
      failures++;
      $display("FAIL eoi_in_assert int_req=%b state=%0d required %b / ASSERT", int_req, dbg_state, exp_req);
    end
    wr(4'h0, 32'h0);
    n = 0;
    while (int_req != 2'b00 && n < 4) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 1 || dbg_state !== S_GAP) begin
      failures++;
      $display("FAIL disable_drop delay=%0d state=%0d required 1 / GAP", n, dbg_state);
    end
    rd(4'h2, d);
    checks++;
    if (d !== (32'h1 << s)) begin
      failures++;
      $display("FAIL disable_pending got=%h required %h", d, 32'h1 << s);
    end
    wr(4'h0, 32'h1 << s);
    wait_req(20, n);
    checks++;
    if (int_req !== exp_req) begin
      failures++;
      $display("FAIL reenable int_req=%b required %b", int_req, exp_req);
    end
    pulse_ack();
    wr(4'h3, 32'h0);
    src_event = '0;
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    int k, n;
    do_reset();
    k = $urandom_range(0, NS - 1);
    src_event[k] = 1'b1; tick();
    src_event[k] = 1'b0; tick();
    src_event[k] = 1'b1;
    wr(4'h2, 32'h1 << k);
    rd(4'h2, d);
    checks++;
    if (d !== (32'h1 << k)) begin
      failures++;
      $display("FAIL w1c_set_wins got=%h required %h", d, 32'h1 << k);
    end
    src_event[k] = 1'b0; tick();
    wr(4'h2, 32'h1 << k);
    rd(4'h2, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL w1c_clear got=%h required 0", d);
    end
    wr(4'h0, 32'h1 << k);
    src_event[k] = 1'b1;
    wait_req(10, n);
    src_event[k] = 1'b0; tick();
    src_event[k] = 1'b1;
    pulse_ack();
    rd(4'h2, d);
    checks++;
    if (d !== (32'h1 << k)) begin
      failures++;
      $display("FAIL ack_set_wins got=%h required %h", d, 32'h1 << k);
    end
    wr(4'h3, 32'h0);
    wait_req(20, n);
    checks++;
    if (n !== GAP + 1 || int_req !== 2'b01) begin
      failures++;
      $display("FAIL reassert latency=%0d int_req=%b required %0d / 01", n, int_req, GAP + 1);
    end
    pulse_ack();
    wr(4'h3, 32'h0);
    src_event = '0;
  endtask

  task automatic test_nmi();
    logic [31:0] d;
    do_reset();
    nmi_event = 1'b1; tick();
    checks++;
    if (nmi_req !== 1'b1) begin
      failures++;
      $display("FAIL nmi_set got=%b required 1", nmi_req);
    end
    nmi_event = 1'b0;
    wr(4'h5, 32'h1);
    checks++;
    if (nmi_req !== 1'b0) begin
      failures++;
      $display("FAIL nmi_clr got=%b required 0", nmi_req);
    end
    nmi_event = 1'b1;
    wr(4'h5, 32'h1);
    checks++;
    if (nmi_req !== 1'b1) begin
      failures++;
      $display("FAIL nmi_set_wins got=%b required 1", nmi_req);
    end
    pulse_ack();
    checks++;
    if (nmi_req !== 1'b1) begin
      failures++;
      $display("FAIL nmi_ack_ignored got=%b required 1", nmi_req);
    end
    rd(4'h4, d);
    checks++;
    if (d !== 32'h1800) begin
      failures++;
      $display("FAIL nmi_status got=%h required 00001800", d);
    end
    wr(4'h5, 32'hFFFF_FFFE);
    checks++;
    if (nmi_req !== 1'b1) begin
      failures++;
      $display("FAIL nmi_clr_bit0_only got=%b required 1", nmi_req);
    end
    wr(4'h5, 32'h1);
    checks++;
    if (nmi_req !== 1'b0) begin
      failures++;
      $display("FAIL nmi_clr_later got=%b required 0", nmi_req);
    end
    nmi_event = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int j, n;
    do_reset();
    j = $urandom_range(0, NS - 1);
    wr(4'h0, 32'hFF);
    src_event[j] = 1'b1;
    wait_req(10, n);
    pulse_ack();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (int_req !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_drop int_req=%b required 00", int_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd(4'h2, d);
    checks++;
    if (d !== (32'h1 << j) || int_req !== 2'b00) begin
      failures++;
      $display("FAIL reset_held_edge pending=%h int_req=%b required %h / 00", d, int_req, 32'h1 << j);
    end
    src_event = '0;
  endtask

  task automatic test_vector();
    logic [31:0] d;
    int n;
    do_reset();
    wr(4'h6, 32'hFE);
    rd(4'h6, d);
`ifdef TILE_IRQ_VECTOR_EN
    checks++;
    if (d !== 32'hFE) begin
      failures++;
      $display("FAIL vbase_rd got=%h required fe", d);
    end
    wr(4'h0, 32'h08);
    src_event[3] = 1'b1;
    wait_req(10, n);
    checks++;
    if (ack_vector_valid !== 1'b0) begin
      failures++;
      $display("FAIL vec_idle valid=%b required 0", ack_vector_valid);
    end
    pulse_ack();
    checks++;
    if (ack_vector_valid !== 1'b1 || ack_vector !== 8'h01) begin
      failures++;
      $display("FAIL vec_out valid=%b vec=%h required 1 / 01", ack_vector_valid, ack_vector);
    end
    tick();
    checks++;
    if (ack_vector_valid !== 1'b0) begin
      failures++;
      $display("FAIL vec_pulse valid=%b required 0", ack_vector_valid);
    end
    wr(4'h3, 32'h0);
    src_event = '0;
`else
    n = 0;
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL vbase_absent got=%h required 0 (n=%0d)", d, n);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority(8);
    test_spurious();
    test_disable();
    test_set_wins();
    test_nmi();
    test_reset_mid();
    test_vector();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
